// File: rtl/regfile_mp.sv
// Parametrised multi-read, single-write register file with sequenced post-reset clear.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int INIT_IDX = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_ptr;
    logic            r_ready;
    logic            r_wr_drop;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_wr_ok;
    logic            w_drop_next;
    logic [XLEN-1:0] w_clr_val;

    // An address is usable if it lies inside the file and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic [AW:0] ext;
        ext = {1'b0, a};
        return (ext < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_wr_ok     = (r_state == S_RUN) && wr_en && addr_ok(wr_addr);
    assign w_drop_next = wr_en && !w_wr_ok;
    assign w_clr_val   = (INIT_IDX != 0) ? XLEN'(r_clr_ptr) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_drop_next;
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_PTR) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage itself is never reset; the clear sequence initialises it instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_ptr] <= w_clr_val;
            end else if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rv;

        assign w_ra = rd_addr[g*AW +: AW];

        always_comb begin
            w_rv = '0;
            if (r_ready && addr_ok(w_ra)) begin
                w_rv = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && (wr_addr == w_ra)) begin
                    w_rv = wr_data;
                end
`endif
            end
        end

        assign rd_data[g*XLEN +: XLEN] = w_rv;
    end

    assign ready   = r_ready;
    assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear/ready timing, writes, dropped writes, forwarding,
// reset mid-clear, and a wide three-port configuration.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // A: 32x32, two ports, zero reg, index debug pattern
    logic [9:0]  a_ra = '0;
    logic [63:0] a_rd;
    logic        a_we = 1'b0;
    logic [4:0]  a_wa = '0;
    logic [31:0] a_wd = '0;
    logic        a_ready, a_drop;

    // B: depth 40 (non power of two)
    logic [11:0] b_ra = '0;
    logic [63:0] b_rd;
    logic        b_we = 1'b0;
    logic [5:0]  b_wa = '0;
    logic [31:0] b_wd = '0;
    logic        b_ready, b_drop;

    // C: 16x64, three ports
    logic [11:0]  c_ra = '0;
    logic [191:0] c_rd;
    logic         c_we = 1'b0;
    logic [3:0]   c_wa = '0;
    logic [63:0]  c_wd = '0;
    logic         c_ready, c_drop;

    regfile_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .INIT_IDX(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_ra), .rd_data(a_rd), .wr_en(a_we),
        .wr_addr(a_wa), .wr_data(a_wd), .ready(a_ready), .wr_drop(a_drop));

    regfile_mp #(.XLEN(32), .DEPTH(40), .NUM_RD(2), .ZERO_REG(1), .INIT_IDX(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_ra), .rd_data(b_rd), .wr_en(b_we),
        .wr_addr(b_wa), .wr_data(b_wd), .ready(b_ready), .wr_drop(b_drop));

    regfile_mp #(.XLEN(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(1), .INIT_IDX(0)) u_c (
        .clk(clk), .rst_n(rst_n), .rd_addr(c_ra), .rd_data(c_rd), .wr_en(c_we),
        .wr_addr(c_wa), .wr_data(c_wd), .ready(c_ready), .wr_drop(c_drop));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        edrop;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd5,  5'd31, 32'd5,  32'd31, 1'b0};
        vt[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd7,  32'd6,  32'hDEADBEEF, 1'b0};
        vt[3] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd1,  32'd0,  32'd1,  1'b0};
        vt[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd2,  32'd0,  32'd2,  1'b1};
        vt[5] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd4,  BYP ? 32'hA5A5A5A5 : 32'd3, 32'd4, 1'b0};
        vt[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vt[7] = '{1'b1, 5'd31, 32'h11,       5'd31, 5'd30, BYP ? 32'h11 : 32'd31, 32'd30, 1'b0};
        vt[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h11, 32'd0,  1'b0};

        // Reset held for two edges, then the clear sequence must take exactly 32 edges.
        a_ra = {5'd31, 5'd5};
        tick();
        tick();
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_drop", 64'(a_drop), 64'd0);
        chk("rst_rd", a_rd, 64'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("clr_ready_%0d", k), 64'(a_ready), (k == 32) ? 64'd1 : 64'd0);
            if (k == 10) chk("clr_rd_zero", a_rd, 64'd0);
        end
        #2;
        chk("init_r5", 64'(a_rd[31:0]), 64'd5);
        chk("init_r31", 64'(a_rd[63:32]), 64'd31);

        // Table: inputs applied, combinational reads checked mid-cycle, then the edge.
        for (int i = 0; i < 9; i++) begin
            a_we = vt[i].we;
            a_wa = vt[i].wa;
            a_wd = vt[i].wd;
            a_ra = {vt[i].ra1, vt[i].ra0};
            #2;
            chk($sformatf("vec%0d_rd0", i), 64'(a_rd[31:0]), 64'(vt[i].e0));
            chk($sformatf("vec%0d_rd1", i), 64'(a_rd[63:32]), 64'(vt[i].e1));
            chk($sformatf("vec%0d_drop", i), 64'(a_drop), 64'(vt[i].edrop));
            tick();
        end
        a_we = 1'b0;

        // Reset in RUN, then again at clear step 10; clear restarts from entry 0.
        rst_n = 1'b0;
        tick();
        chk("run_rst_ready", 64'(a_ready), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", 64'(a_ready), 64'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            a_we = (k == 5);
            a_wa = 5'd2;
            a_wd = 32'hBAD;
            tick();
            chk($sformatf("reclr_ready_%0d", k), 64'(a_ready), (k == 32) ? 64'd1 : 64'd0);
            if (k == 5) chk("clr_wr_drop", 64'(a_drop), 64'd1);
            if (k == 6) chk("clr_drop_clear", 64'(a_drop), 64'd0);
        end
        a_we = 1'b0;
        a_ra = {5'd9, 5'd2};
        #2;
        chk("clr_wr_noeffect", 64'(a_rd[31:0]), 64'd2);
        chk("reclr_r9", 64'(a_rd[63:32]), 64'd9);

        // Wait (bounded) for the larger and wider instances to finish clearing.
        for (int k = 0; k < 200 && !(b_ready && c_ready); k++) tick();
        chk("bc_ready", 64'(b_ready && c_ready), 64'd1);

        // B: write beyond depth is dropped; last valid entry writes normally.
        b_we = 1'b1;
        b_wa = 6'd40;
        b_wd = 32'h77;
        b_ra = {6'd39, 6'd40};
        tick();
        chk("b_drop_oob", 64'(b_drop), 64'd1);
        b_wa = 6'd39;
        b_wd = 32'h55;
        #2;
        chk("b_rd_oob", 64'(b_rd[31:0]), 64'd0);
        chk("b_rd39_old", 64'(b_rd[63:32]), BYP ? 64'h55 : 64'd0);
        tick();
        b_we = 1'b0;
        b_ra = {6'd63, 6'd39};
        #2;
        chk("b_drop_ok", 64'(b_drop), 64'd0);
        chk("b_rd39", 64'(b_rd[31:0]), 64'h55);
        chk("b_rd63", 64'(b_rd[63:32]), 64'd0);

        // C: 64-bit write read back on all three ports.
        c_we = 1'b1;
        c_wa = 4'd15;
        c_wd = 64'hFFFF_0000_FFFF_0000;
        c_ra = {4'd15, 4'd15, 4'd15};
        tick();
        c_we = 1'b0;
        #2;
        chk("c_rd0", c_rd[63:0], 64'hFFFF_0000_FFFF_0000);
        chk("c_rd1", c_rd[127:64], 64'hFFFF_0000_FFFF_0000);
        chk("c_rd2", c_rd[191:128], 64'hFFFF_0000_FFFF_0000);
        chk("c_drop", 64'(c_drop), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
